// File: rtl/bus_map_pkg.sv
// Shared definitions for the 6502 bus map: regions, wait-FSM states,
// default wait counts and the address-to-region decode.
package bus_map_pkg;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_IO       = 2'd1,
    REG_ROM      = 2'd2,
    REG_UNMAPPED = 2'd3
  } region_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_e;

  localparam int RAM_WAIT_DEFAULT = 0;
  localparam int IO_WAIT_DEFAULT  = 3;
  localparam int ROM_WAIT_DEFAULT = 2;

  // addr_hi is A15..A11; the 0x4000-0x47FF hole is deliberately unmapped.
  function automatic region_e decode_region(input logic [4:0] addr_hi);
    region_e r;
    if (addr_hi[4])
      r = REG_ROM;
    else if (!addr_hi[3])
      r = REG_RAM;
    else if (addr_hi[2:0] != 3'b000)
      r = REG_IO;
    else
      r = REG_UNMAPPED;
    return r;
  endfunction

endpackage

// File: rtl/bus_region_decode.sv
// Pure combinational region map from A15..A11, shared with bus monitors.
module bus_region_decode
  import bus_map_pkg::*;
(
  input  logic [4:0] addr_hi,
  output logic [1:0] region
);

  assign region = decode_region(addr_hi);

endmodule

// File: rtl/bus_wait_ctrl.sv
// Wait-state controller: classifies each 6502 bus cycle on the phi2 rise and
// holds RDY low for a per-region, software-configurable number of phase cycles.
module bus_wait_ctrl
  import bus_map_pkg::*;
#(
  parameter int WAIT_W       = 4,
  parameter int RAM_WAIT_DEF = RAM_WAIT_DEFAULT,
  parameter int IO_WAIT_DEF  = IO_WAIT_DEFAULT,
  parameter int ROM_WAIT_DEF = ROM_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              phi2,
  input  logic [4:0]        addr_hi,
  input  logic              io_ack,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [WAIT_W-1:0] cfg_data,
  output logic              rdy,
  output logic              cycle_start,
  output logic [1:0]        region,
  output logic              busy,
  output logic              unmapped_err
);

  localparam logic [0:0] IDLE = ST_IDLE;
  localparam logic [0:0] WAIT = ST_WAIT;

  logic [0:0]        state;
  logic              phi2_q;
  logic              rise;
  logic [1:0]        dec_region;
  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] ram_wait;
  logic [WAIT_W-1:0] io_wait;
  logic [WAIT_W-1:0] rom_wait;
  logic [WAIT_W-1:0] load_val;

  bus_region_decode u_decode (
    .addr_hi (addr_hi),
    .region  (dec_region)
  );

  assign rise = phi2 & ~phi2_q;

  // Config registers are read before this edge's write lands, so a write in
  // the same clk as a rise leaves that cycle on the old wait count.
  always_comb begin
    load_val = '0;
    case (dec_region)
      REG_RAM: load_val = ram_wait;
      REG_IO:  load_val = io_wait;
      REG_ROM: load_val = rom_wait;
      default: load_val = '0;
    endcase
  end

  // Handshake: rdy=0 stalls the CPU; io_ack is a single-clk pulse honoured
  // only while waiting on an I/O cycle, and rdy rises on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phi2_q       <= 1'b0;
      cnt          <= '0;
      cycle_start  <= 1'b0;
      region       <= REG_RAM;
      unmapped_err <= 1'b0;
      ram_wait     <= WAIT_W'(RAM_WAIT_DEF);
      io_wait      <= WAIT_W'(IO_WAIT_DEF);
      rom_wait     <= WAIT_W'(ROM_WAIT_DEF);
    end else begin
      phi2_q      <= phi2;
      cycle_start <= 1'b0;

      if (cfg_we) begin
        case (cfg_sel)
          2'd0:    ram_wait <= cfg_data;
          2'd1:    io_wait  <= cfg_data;
          2'd2:    rom_wait <= cfg_data;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (rise) begin
            cycle_start <= 1'b1;
            region      <= dec_region;
            cnt         <= load_val;
            if (dec_region == REG_UNMAPPED)
              unmapped_err <= 1'b1;
            if (load_val != '0)
              state <= WAIT;
          end
        end
        WAIT: begin
          if (io_ack && region == REG_IO) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (rise && cnt != '0) begin
            cnt <= cnt - WAIT_W'(1);
            if (cnt == WAIT_W'(1))
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == WAIT);
  assign rdy  = ~busy;

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Directed bench for bus_wait_ctrl: drives 6502-style phi2 bus cycles and
// scores region, stall length and cycle_start count per access.
module tb_bus_wait_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       phi2;
  logic [4:0] addr_hi;
  logic       io_ack;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [3:0] cfg_data;
  logic       rdy;
  logic       cycle_start;
  logic [1:0] region;
  logic       busy;
  logic       unmapped_err;

  int checks = 0;
  int errors = 0;
  int cs_count = 0;
  logic [9:0] exp_q[$];

  bus_wait_ctrl #(
    .WAIT_W       (4),
    .RAM_WAIT_DEF (0),
    .IO_WAIT_DEF  (3),
    .ROM_WAIT_DEF (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .phi2         (phi2),
    .addr_hi      (addr_hi),
    .io_ack       (io_ack),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .rdy          (rdy),
    .cycle_start  (cycle_start),
    .region       (region),
    .busy         (busy),
    .unmapped_err (unmapped_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cycle_start === 1'b1) cs_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [3:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_we = 1'b0;
    tick();
  endtask

  // One full bus access: counts phase periods with rdy low after the rise.
  task automatic access(input string tag, input logic [4:0] a, input logic [1:0] er,
                        input int es, input bit ack, input bit cfg_now,
                        input logic [1:0] sel, input logic [3:0] data);
    int stall;
    int guard;
    int cs0;
    logic [1:0] obs_region;
    logic [9:0] e;
    exp_q.push_back({er, 8'(es)});
    cs0 = cs_count;
    addr_hi = a;
    phi2 = 1'b1;
    if (cfg_now) begin
      cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    end
    tick();
    cfg_we = 1'b0;
    tick();
    obs_region = region;
    stall = 0;
    guard = 0;
    while (!rdy && guard < 40) begin
      guard++;
      stall++;
      repeat (2) tick();
      if (ack && guard == 1) begin
        io_ack = 1'b1;
        tick();
        io_ack = 1'b0;
        check({tag, "_ack_ignored_rdy"}, 32'(rdy), 32'd0);
      end else begin
        tick();
      end
      phi2 = 1'b0;
      repeat (4) tick();
      phi2 = 1'b1;
      repeat (2) tick();
    end
    check({tag, "_no_timeout"}, 32'(guard < 40), 32'd1);
    repeat (3) tick();
    phi2 = 1'b0;
    repeat (4) tick();
    e = exp_q.pop_front();
    check({tag, "_region"}, 32'(obs_region), 32'(e[9:8]));
    check({tag, "_stall"}, 32'(stall), 32'(e[7:0]));
    check({tag, "_cycle_starts"}, 32'(cs_count - cs0), 32'd1);
  endtask

  initial begin
    rst = 1'b1; phi2 = 1'b0; addr_hi = '0; io_ack = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
    repeat (3) tick();
    check("reset_rdy", 32'(rdy), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cycle_start", 32'(cycle_start), 32'd0);
    check("reset_region", 32'(region), 32'd0);
    check("reset_err", 32'(unmapped_err), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    access("ram", 5'b00000, 2'd0, 0, 1'b0, 1'b0, 2'd0, 4'd0);
    access("rom_def", 5'b10000, 2'd2, 2, 1'b0, 1'b0, 2'd0, 4'd0);

    // I/O early release via io_ack
    addr_hi = 5'b01100;
    phi2 = 1'b1;
    repeat (2) tick();
    check("io_region", 32'(region), 32'd1);
    check("io_busy_before_ack", 32'(busy), 32'd1);
    check("io_rdy_before_ack", 32'(rdy), 32'd0);
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    check("io_ack_rdy", 32'(rdy), 32'd1);
    check("io_ack_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    phi2 = 1'b0;
    repeat (4) tick();

    access("rom_ack", 5'b10000, 2'd2, 2, 1'b1, 1'b0, 2'd0, 4'd0);
    access("rom_same_clk_cfg", 5'b10000, 2'd2, 2, 1'b0, 1'b1, 2'd2, 4'd5);
    access("rom_cfg5", 5'b10111, 2'd2, 5, 1'b0, 1'b0, 2'd0, 4'd0);
    cfg_write(2'd2, 4'd15);
    access("rom_cfg15", 5'b11000, 2'd2, 15, 1'b0, 1'b0, 2'd0, 4'd0);
    access("io_full", 5'b01001, 2'd1, 3, 1'b0, 1'b0, 2'd0, 4'd0);
    cfg_write(2'd3, 4'd7);
    access("ram_sel3_ignored", 5'b00111, 2'd0, 0, 1'b0, 1'b0, 2'd0, 4'd0);
    cfg_write(2'd0, 4'd1);
    access("ram_cfg1", 5'b00010, 2'd0, 1, 1'b0, 1'b0, 2'd0, 4'd0);

    access("unmapped", 5'b01000, 2'd3, 0, 1'b0, 1'b0, 2'd0, 4'd0);
    check("unmapped_err_set", 32'(unmapped_err), 32'd1);
    access("ram_after_unmapped", 5'b00000, 2'd0, 1, 1'b0, 1'b0, 2'd0, 4'd0);
    check("unmapped_err_sticky", 32'(unmapped_err), 32'd1);

    // Reset during an I/O wait
    addr_hi = 5'b01100;
    phi2 = 1'b1;
    repeat (2) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    phi2 = 1'b0;
    tick();
    check("mid_rst_rdy", 32'(rdy), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(unmapped_err), 32'd0);
    check("mid_rst_region", 32'(region), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    access("rom_after_rst", 5'b10000, 2'd2, 2, 1'b0, 1'b0, 2'd0, 4'd0);
    access("ram_after_rst", 5'b00000, 2'd0, 0, 1'b0, 1'b0, 2'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
